// File: rtl/mac_tx_arb_if.sv
// mac_tx_arb_if: N frame sources on one side, one MAC TX byte stream on the other.
interface mac_tx_arb_if #(
   parameter int N = 2
);
   logic [N-1:0]   req;
   logic [N-1:0]   gnt;
   logic [8*N-1:0] in_data;
   logic [N-1:0]   in_valid;
   logic [N-1:0]   in_sof;
   logic [N-1:0]   in_eof;
   logic [7:0]     mac_tx_data;
   logic           mac_tx_valid;
   logic           mac_tx_sof;
   logic           mac_tx_eof;

   modport master (
      output req, in_data, in_valid, in_sof, in_eof,
      input  gnt, mac_tx_data, mac_tx_valid, mac_tx_sof, mac_tx_eof
   );

   modport slave (
      input  req, in_data, in_valid, in_sof, in_eof,
      output gnt, mac_tx_data, mac_tx_valid, mac_tx_sof, mac_tx_eof
   );
endinterface

// File: rtl/mac_tx_arb.sv
// mac_tx_arb: frame-level round-robin arbiter in front of the MAC TX port.
// Define MAC_TX_ARB_STAT_EN for per-source 16-bit frame counters (stat_frames/stat_clr).
module mac_tx_arb #(
   parameter int N           = 2,
   parameter int IFG_CYCLES  = 12,
   parameter int SOF_TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,
   mac_tx_arb_if.slave     bus,
   output logic            timeout,
   output logic            busy
`ifdef MAC_TX_ARB_STAT_EN
   ,
   input  logic            stat_clr,
   output logic [16*N-1:0] stat_frames
`endif
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
   localparam int TW = (SOF_TIMEOUT > 1) ? $clog2(SOF_TIMEOUT) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(N - 1);
   localparam logic [GW-1:0] G_LAST =
      GW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
   localparam logic [TW-1:0] T_LAST =
      TW'((SOF_TIMEOUT > 0) ? SOF_TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {IDLE, GRANT, XFER, GAP} state_t;

   // Zero gap skips GAP entirely so the next grant can follow at once.
   localparam state_t AFTER = (IFG_CYCLES == 0) ? IDLE : GAP;

   state_t          cur, nxt;
   logic [N-1:0]    gnt_q, gnt_d;
   logic [PW-1:0]   sel_q, sel_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [PW-1:0]   pick, idx;
   logic            hit;
   logic [GW-1:0]   gcnt_q, gcnt_d;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic            to_d;
   logic [7:0]      d_q, d_d;
   logic            v_q, v_d;
   logic            s_q, s_d;
   logic            e_q, e_d;

   logic [7:0]      sd;
   logic            sv, ss, se, sr;

   assign sd = bus.in_data[{sel_q, 3'b000} +: 8];
   assign sv = bus.in_valid[sel_q];
   assign ss = bus.in_sof[sel_q];
   assign se = bus.in_eof[sel_q];
   assign sr = bus.req[sel_q];

   always_comb begin
      pick = '0;
      idx  = '0;
      hit  = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx = PW'((int'(ptr_q) + k) % N);
         if (!hit && bus.req[idx]) begin
            hit  = 1'b1;
            pick = idx;
         end
      end
   end

   always_comb begin
      nxt    = cur;
      gnt_d  = gnt_q;
      sel_d  = sel_q;
      ptr_d  = ptr_q;
      gcnt_d = gcnt_q;
      tcnt_d = tcnt_q;
      to_d   = 1'b0;
      d_d    = '0;
      v_d    = 1'b0;
      s_d    = 1'b0;
      e_d    = 1'b0;
      unique case (cur)
         IDLE: begin
            if (hit) begin
               nxt         = GRANT;
               gnt_d       = '0;
               gnt_d[pick] = 1'b1;
               sel_d       = pick;
               ptr_d       = (pick == P_LAST) ? '0 : pick + 1'b1;
               tcnt_d      = '0;
            end
         end
         GRANT: begin
            if (sv && ss) begin
               d_d = sd;
               v_d = 1'b1;
               s_d = 1'b1;
               e_d = se;
               if (se) begin
                  nxt    = AFTER;
                  gnt_d  = '0;
                  gcnt_d = '0;
               end else begin
                  nxt = XFER;
               end
            end else if (!sr) begin
               nxt   = IDLE;
               gnt_d = '0;
            end else if (tcnt_q == T_LAST) begin
               nxt    = AFTER;
               gnt_d  = '0;
               gcnt_d = '0;
               to_d   = 1'b1;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         XFER: begin
            d_d = sd;
            v_d = sv;
            s_d = sv & ss;
            e_d = sv & se;
            if (sv && se) begin
               nxt    = AFTER;
               gnt_d  = '0;
               gcnt_d = '0;
            end
         end
         GAP: begin
            if (gcnt_q == G_LAST) nxt = IDLE;
            else gcnt_d = gcnt_q + 1'b1;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur     <= IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
         gcnt_q  <= '0;
         tcnt_q  <= '0;
         timeout <= 1'b0;
         d_q     <= '0;
         v_q     <= 1'b0;
         s_q     <= 1'b0;
         e_q     <= 1'b0;
      end else begin
         cur     <= nxt;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         gcnt_q  <= gcnt_d;
         tcnt_q  <= tcnt_d;
         timeout <= to_d;
         d_q     <= d_d;
         v_q     <= v_d;
         s_q     <= s_d;
         e_q     <= e_d;
      end
   end

   assign bus.gnt          = gnt_q;
   assign bus.mac_tx_data  = d_q;
   assign bus.mac_tx_valid = v_q;
   assign bus.mac_tx_sof   = s_q;
   assign bus.mac_tx_eof   = e_q;
   assign busy             = (cur != IDLE);

`ifdef MAC_TX_ARB_STAT_EN
   logic [N-1:0][15:0] frames;

   // e_d is the eof being forwarded this clock; clear takes priority.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frames <= '0;
      end else if (stat_clr) begin
         frames <= '0;
      end else if (e_d) begin
         frames[sel_q] <= frames[sel_q] + 16'd1;
      end
   end

   assign stat_frames = frames;
`endif
endmodule

// File: tb/tb_mac_tx_arb.sv
// tb_mac_tx_arb: directed checks of grant rotation, gap, timeout and reset.
module tb_mac_tx_arb;
   localparam int N = 2;

   logic clk = 1'b0;
   logic rst;
   logic to_a, busy_a, to_z, busy_z;
   int   n_chk = 0;
   int   n_fail = 0;

   mac_tx_arb_if #(.N(N)) b ();
   mac_tx_arb_if #(.N(N)) bz ();

`ifdef MAC_TX_ARB_STAT_EN
   logic            stat_clr;
   logic [16*N-1:0] stat_a, stat_z;
`endif

   always #5 clk = ~clk;

   mac_tx_arb #(.N(N), .IFG_CYCLES(12), .SOF_TIMEOUT(255)) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(b),
      .timeout(to_a),
      .busy(busy_a)
`ifdef MAC_TX_ARB_STAT_EN
      ,
      .stat_clr(stat_clr),
      .stat_frames(stat_a)
`endif
   );

   mac_tx_arb #(.N(N), .IFG_CYCLES(0), .SOF_TIMEOUT(255)) u_z (
      .clk(clk),
      .rst(rst),
      .bus(bz),
      .timeout(to_z),
      .busy(busy_z)
`ifdef MAC_TX_ARB_STAT_EN
      ,
      .stat_clr(stat_clr),
      .stat_frames(stat_z)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      b.req = '0;  b.in_valid = '0;  b.in_sof = '0;  b.in_eof = '0;
      b.in_data = '0;
      bz.req = '0; bz.in_valid = '0; bz.in_sof = '0; bz.in_eof = '0;
      bz.in_data = '0;
   endtask

   task automatic send_frame(input string tag, input int src, input int len,
                             input int nsend, input logic [7:0] base,
                             input bit drop, input bit garb);
      for (int k = 0; k < nsend; k++) begin
         b.in_valid[src] = 1'b1;
         b.in_sof[src] = (k == 0);
         b.in_eof[src] = (k == len - 1);
         b.in_data[8*src +: 8] = base + 8'(k);
         if (garb) begin
            b.in_valid[1-src] = 1'($urandom);
            b.in_sof[1-src] = 1'($urandom);
            b.in_eof[1-src] = 1'($urandom);
            b.in_data[8*(1-src) +: 8] = 8'($urandom);
         end
         if (drop && k == len - 1) b.req[src] = 1'b0;
         step();
         check({tag, "_byte"},
               {b.mac_tx_valid, b.mac_tx_sof, b.mac_tx_eof, b.mac_tx_data},
               {1'b1, k == 0, k == len - 1, base + 8'(k)});
      end
      b.in_valid = '0;
      b.in_sof = '0;
      b.in_eof = '0;
      if (nsend == len) check({tag, "_gnt_clr"}, b.gnt, '0);
   endtask

   task automatic wait_gnt(output int n, output int bad);
      n = 0;
      bad = 0;
      do begin
         step();
         n++;
         if (b.mac_tx_valid) bad++;
      end while (b.gnt == '0 && n < 400);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy_a && n < 400) begin
         step();
         n++;
      end
      check({tag, "_idle"}, busy_a, 1'b0);
   endtask

   initial begin
      int n, bad, src;
      rst = 1'b0;
      idle_inputs();
`ifdef MAC_TX_ARB_STAT_EN
      stat_clr = 1'b0;
`endif
      step();
      step();
      check("rst_gnt", b.gnt, '0);
      check("rst_mac", {b.mac_tx_valid, b.mac_tx_sof, b.mac_tx_eof,
                        b.mac_tx_data}, '0);
      check("rst_busy", busy_a, 1'b0);
      check("rst_timeout", to_a, 1'b0);
      rst = 1'b1;

      bz.req[0] = 1'b1;
      step();
      check("z_gnt", bz.gnt, 2'b01);
      bz.in_valid[0] = 1'b1;
      bz.in_sof[0] = 1'b1;
      bz.in_eof[0] = 1'b1;
      bz.in_data[7:0] = 8'h5A;
      step();
      check("z_byte", {bz.mac_tx_valid, bz.mac_tx_sof, bz.mac_tx_eof,
                       bz.mac_tx_data}, {3'b111, 8'h5A});
      check("z_gnt_clr", bz.gnt, '0);
      check("z_idle", busy_z, 1'b0);
      bz.in_valid = '0;
      bz.in_sof = '0;
      bz.in_eof = '0;
      step();
      check("z_regnt", bz.gnt, 2'b01);
      bz.req = '0;
      step();
      check("z_drop", bz.gnt, '0);

      b.req[0] = 1'b1;
      step();
      check("t1_gnt", b.gnt, 2'b01);
      send_frame("t1", 0, 64, 64, 8'h00, 1'b0, 1'b0);
      wait_gnt(n, bad);
      check("t1_ifg", n, 13);
      check("t1_gap_quiet", bad, 0);
      check("t1_regnt", b.gnt, 2'b01);
      b.req = '0;
      step();
      check("t1_release", b.gnt, '0);
      check("t1_busy", busy_a, 1'b0);

      b.req = 2'b11;
      for (int f = 0; f < 6; f++) begin
         wait_gnt(n, bad);
         check("t2_wait", n, (f == 0) ? 1 : 13);
         check("t2_gap_quiet", bad, 0);
         src = (f % 2 == 0) ? 1 : 0;
         check("t2_gnt", b.gnt, 64'(1) << src);
         send_frame("t2", src, 4, 4, 8'(16 * f), f >= 4, 1'b0);
      end
      wait_idle("t2");

      b.req = 2'b11;
      step();
      check("t3_gnt", b.gnt, 2'b10);
      n = 0;
      do begin
         step();
         n++;
      end while (!to_a && n < 300);
      check("t3_latency", n, 255);
      check("t3_gnt_clr", b.gnt, '0);
      step();
      check("t3_pulse", to_a, 1'b0);
      wait_gnt(n, bad);
      check("t3_regap", n + 1, 13);
      check("t3_gnt0", b.gnt, 2'b01);

      send_frame("t5", 0, 16, 16, 8'hA0, 1'b1, 1'b1);
      b.req[1] = 1'b0;
      wait_idle("t5");

`ifdef MAC_TX_ARB_STAT_EN
      check("stat_count", stat_a, {16'd3, 16'd5});
`endif

      b.req = 2'b01;
      step();
      check("t6_gnt", b.gnt, 2'b01);
      send_frame("t6", 0, 64, 10, 8'h40, 1'b0, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      check("t6_async_gnt", b.gnt, '0);
      check("t6_async_mac", {b.mac_tx_valid, b.mac_tx_sof, b.mac_tx_eof,
                             b.mac_tx_data}, '0);
      check("t6_async_busy", busy_a, 1'b0);
`ifdef MAC_TX_ARB_STAT_EN
      check("t6_stat_rst", stat_a, '0);
`endif
      idle_inputs();
      step();
      rst = 1'b1;
      b.req = 2'b11;
      step();
      check("t6_first", b.gnt, 2'b01);
      b.req = '0;
      step();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
